// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Oversamples rx on the system clock, realigns
// its baud counter to the middle of each start bit, samples every bit at its
// centre and presents each good byte on a valid/ready handshake.
module uart_rx #(
  parameter int unsigned CLOCK_HZ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CPB      = CLOCK_HZ / BAUD_RATE;
  localparam logic [31:0] CPB_LAST = 32'(CPB - 1);
  localparam logic [31:0] CPB_HALF = 32'(CPB / 2);

  generate
    if (CPB < 2) begin : g_bad_cpb
      $error("uart_rx: CLOCK_HZ / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sync_p0;
  logic        r_sync_p1;
  logic        w_rx_s;

  logic [31:0] r_count;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;

  logic        w_tick;
  logic        w_start;
  logic        w_clr_idx;
  logic        w_shift_en;
  logic        w_byte_done;
  logic        w_stop_bad;
  logic        w_accept;

  assign w_rx_s   = r_sync_p1;
  assign w_tick   = (r_count == CPB_LAST) && (r_state != S_IDLE);
  assign w_accept = r_valid && rx_ready;

  // Two-flop synchronizer on the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= rx;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencing: next state and per-edge strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_clr_idx   = 1'b0;
    w_shift_en  = 1'b0;
    w_byte_done = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_start     = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_rx_s) begin
            w_clr_idx   = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            // Glitch shorter than half a bit: drop it silently.
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_byte_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low must return high before a new start is accepted.
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Baud counter: reloaded to half a bit on start detect so ticks land mid-bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= 32'd0;
    end else if (w_start) begin
      r_count <= CPB_HALF;
    end else if (w_tick) begin
      r_count <= 32'd0;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  // Data shifter, LSB first; bit index counts the eight data samples.
  always_ff @(posedge clk) begin
    if (w_clr_idx) begin
      r_bit_idx <= 3'd0;
    end else if (w_shift_en) begin
      r_shift   <= {w_rx_s, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Output byte, handshake and one-cycle status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_byte_done) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        // Overwriting a byte the consumer never took is an overrun; a
        // simultaneous accept makes room for it.
        if (r_valid && !rx_ready) begin
          r_ovr <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at CPB=10: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int          LAT    = 97;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLOCK_HZ (CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } ev_t;

  ev_t  acc_q[$];
  ev_t  exp_acc[$];
  int   fe_q[$];
  int   exp_fe[$];
  int   ov_q[$];
  int   exp_ov[$];
  int   bfall_q[$];
  int   busy_cycles = 0;
  logic busy_prev   = 1'b0;

  // Observe outputs 1 ns after each falling edge, clear of both clock edges.
  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (rx_valid && rx_ready) acc_q.push_back('{rx_data, cyc});
      if (frame_err) fe_q.push_back(cyc);
      if (overrun) ov_q.push_back(cyc);
      if (busy) busy_cycles++;
      if (busy_prev && !busy) bfall_q.push_back(cyc);
    end
    busy_prev = busy;
  end

  task automatic chk(input string tag, input string what, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s[%0d]: got %0h, expected %0h", tag, what, idx, act, exp);
    end
  endtask

  task automatic clear_all();
    acc_q.delete();
    exp_acc.delete();
    fe_q.delete();
    exp_fe.delete();
    ov_q.delete();
    exp_ov.delete();
    bfall_q.delete();
    busy_cycles = 0;
  endtask

  task automatic check_queues(input string tag);
    chk(tag, "n_bytes", 0, acc_q.size(), exp_acc.size());
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++) begin
      chk(tag, "data", i, 32'(acc_q[i].d), 32'(exp_acc[i].d));
      chk(tag, "valid_cycle", i, acc_q[i].c, exp_acc[i].c);
    end
    chk(tag, "n_frame_err", 0, fe_q.size(), exp_fe.size());
    for (int i = 0; i < fe_q.size() && i < exp_fe.size(); i++)
      chk(tag, "frame_err_cycle", i, fe_q[i], exp_fe[i]);
    chk(tag, "n_overrun", 0, ov_q.size(), exp_ov.size());
    for (int i = 0; i < ov_q.size() && i < exp_ov.size(); i++)
      chk(tag, "overrun_cycle", i, ov_q[i], exp_ov[i]);
    clear_all();
  endtask

  // Drive one 8N1 frame, 10 clocks per bit; p is the edge that first sees start.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int p);
    rx = 1'b0;
    p  = cyc + 1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int         p, p1, p2, k;
    logic [7:0] d;
    logic       stop;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    tbl[7] = '{8'hC6, 1'b0, 1'b0, 8'h00, 1'b1};

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", "rx_data", 0, 32'(rx_data), 32'h0);
    chk("reset", "rx_valid", 0, 32'(rx_valid), 32'h0);
    chk("reset", "busy", 0, 32'(busy), 32'h0);
    chk("reset", "frame_err", 0, 32'(frame_err), 32'h0);
    chk("reset", "overrun", 0, 32'(overrun), 32'h0);
    resetn = 1'b1;
    idle(20);
    clear_all();

    // Table-driven frames
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, p);
      if (!tbl[i].stop) repeat (20) @(negedge clk);
      idle(15);
      chk("table", "n_bytes", i, acc_q.size(), 32'(tbl[i].exp_valid));
      if (acc_q.size() > 0 && tbl[i].exp_valid) begin
        chk("table", "data", i, 32'(acc_q[0].d), 32'(tbl[i].exp_data));
        chk("table", "valid_cycle", i, acc_q[0].c, p + LAT);
      end
      chk("table", "n_frame_err", i, fe_q.size(), 32'(tbl[i].exp_ferr));
      if (fe_q.size() > 0 && tbl[i].exp_ferr)
        chk("table", "frame_err_cycle", i, fe_q[0], p + LAT);
      chk("table", "n_overrun", i, ov_q.size(), 32'h0);
      clear_all();
    end

    // Single byte: valid for one cycle, busy drops with it
    send_frame(8'hA5, 1'b1, p);
    idle(10);
    chk("a5", "busy_cycles", 0, busy_cycles, 95);
    chk("a5", "n_busy_fall", 0, bfall_q.size(), 1);
    if (bfall_q.size() > 0) chk("a5", "busy_fall_cycle", 0, bfall_q[0], p + LAT);
    exp_acc.push_back('{8'hA5, p + LAT});
    check_queues("a5");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, p1);
    send_frame(8'hFF, 1'b1, p2);
    idle(10);
    exp_acc.push_back('{8'h00, p1 + LAT});
    exp_acc.push_back('{8'hFF, p1 + LAT + 100});
    check_queues("b2b");

    // False start: 3-clock low glitch
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    chk("glitch", "busy_cycles", 0, busy_cycles, 5);
    check_queues("glitch");

    // Bad stop bit, line held low, then a good frame
    send_frame(8'h3C, 1'b0, p1);
    repeat (40) @(negedge clk);
    idle(10);
    send_frame(8'h81, 1'b1, p2);
    idle(10);
    exp_fe.push_back(p1 + LAT);
    exp_acc.push_back('{8'h81, p2 + LAT});
    check_queues("break");

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, p1);
    chk("ovr", "valid_first", 0, 32'(rx_valid), 32'h1);
    chk("ovr", "data_first", 0, 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b1, p2);
    idle(5);
    chk("ovr", "valid_held", 0, 32'(rx_valid), 32'h1);
    chk("ovr", "data_new", 0, 32'(rx_data), 32'h22);
    exp_ov.push_back(p2 + LAT);
    k = cyc;
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr", "valid_after_accept", 0, 32'(rx_valid), 32'h0);
    exp_acc.push_back('{8'h22, k});
    check_queues("ovr");

    // Asynchronous reset in the middle of the data bits
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, p);
    idle(5);
    chk("rst_mid", "valid_before", 0, 32'(rx_valid), 32'h1);
    clear_all();
    rx = 1'b0;
    repeat (35) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid", "rx_data", 0, 32'(rx_data), 32'h0);
    chk("rst_mid", "rx_valid", 0, 32'(rx_valid), 32'h0);
    chk("rst_mid", "busy", 0, 32'(busy), 32'h0);
    chk("rst_mid", "frame_err", 0, 32'(frame_err), 32'h0);
    chk("rst_mid", "overrun", 0, 32'(overrun), 32'h0);
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    idle(55);
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, p);
    idle(10);
    exp_acc.push_back('{8'h5A, p + LAT});
    check_queues("rst_mid");

    // Randomized frames against the frame-level model
    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, stop, p);
      if (stop) exp_acc.push_back('{d, p + LAT});
      else      exp_fe.push_back(p + LAT);
      idle(stop ? $urandom_range(0, 12) : $urandom_range(1, 12));
    end
    idle(15);
    check_queues("rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
